color_bounce_engine: RTL

Parametrised successor to the single-ball colour-bounce update logic. It handles NUM_PLATS platforms/keys, a configurable bounce profile and an explicit game FSM (IDLE/FALL/RISE/OVER). It also adds key edge detection, a guaranteed-matchable colour shuffle, score saturation and a high-score register. It sits between the top-level controller (which supplies a frame-rate `tick`) and the draw/erase datapath, which consumes ball/platform positions and colours.

---
 rtl/color_bounce_engine_pkg.sv | 20 ++
 rtl/color_bounce_engine_if.sv | 32 +++
 rtl/color_bounce_engine_picker.sv | 39 +++
 rtl/color_bounce_engine.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/color_bounce_engine_pkg.sv
// Shared definitions for the colour-bounce engine: game state encoding,
// colour-generator LFSR taps and score width.
package color_bounce_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FALL = 2'd1,
    ST_RISE = 2'd2,
    ST_OVER = 2'd3
  } state_e;

  // Galois form of x^16 + x^14 + x^13 + x^11 + 1, shifting right.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int          SCORE_W   = 16;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/color_bounce_engine_if.sv
// Game-step bus between the controller (master) and the bounce engine (slave).
interface color_bounce_engine_if #(
  parameter int NUM_PLATS = 4,
  parameter int POS_W     = 8,
  parameter int COLOR_W   = 3
);
  logic                                           tick;
  logic                                           start;
  logic [NUM_PLATS-1:0]                           keys;
  logic [NUM_PLATS*POS_W-1:0]                     plat_pos;
  logic [POS_W-1:0]                               ball_pos;
  logic [POS_W-1:0]                               prev_ball;
  logic [COLOR_W-1:0]                             ball_color;
  logic [NUM_PLATS*COLOR_W-1:0]                   plat_colors;
  logic [color_bounce_engine_pkg::SCORE_W-1:0]    score;
  logic [color_bounce_engine_pkg::SCORE_W-1:0]    high_score;
  logic                                           gameover;
  logic                                           hit;
  logic                                           miss;

  modport slave (
    input  tick, start, keys, plat_pos,
    output ball_pos, prev_ball, ball_color, plat_colors,
           score, high_score, gameover, hit, miss
  );

  modport master (
    output tick, start, keys, plat_pos,
    input  ball_pos, prev_ball, ball_color, plat_colors,
           score, high_score, gameover, hit, miss
  );
endinterface

// File: rtl/color_bounce_engine_picker.sv
// Free-running colour LFSR; exposes a full set of platform colours and the
// index of the platform whose colour the ball must take.
module color_lfsr_picker
  import color_bounce_engine_pkg::*;
#(
  parameter int          NUM_PLATS = 4,
  parameter int          COLOR_W   = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          IDX_W     = (NUM_PLATS > 1) ? $clog2(NUM_PLATS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic [NUM_PLATS*COLOR_W-1:0] draw_colors_o,
  output logic [IDX_W-1:0]             target_idx_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Next LFSR value; draws wider than 16 bits wrap around the register.
  always_comb begin
    lfsr_d        = lfsr_step(lfsr_q);
    draw_colors_o = '0;
    for (int i = 0; i < NUM_PLATS * COLOR_W; i++) begin
      draw_colors_o[i] = lfsr_q[i % 16];
    end
    target_idx_o = IDX_W'(32'(lfsr_q) % NUM_PLATS);
  end

  // LFSR register, advancing every clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/color_bounce_engine.sv
// Ball/platform game engine: key edge capture, game FSM, hit detection,
// scoring and colour shuffling. Every output is registered.
module color_bounce_engine
  import color_bounce_engine_pkg::*;
#(
  parameter int          NUM_PLATS    = 4,
  parameter int          POS_W        = 8,
  parameter int          COLOR_W      = 3,
  parameter int          BOUNCE_STEPS = 65,
  parameter int          HIT_WINDOW   = 4,
  parameter int          FLOOR_Y      = 160,
  parameter int          START_Y      = 0,
  parameter int          MISS_KILLS   = 0,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  reset,
  color_bounce_engine_if.slave  bus
);

  localparam int IDX_W = (NUM_PLATS > 1) ? $clog2(NUM_PLATS) : 1;
  localparam int UPC_W = $clog2(BOUNCE_STEPS + 1);
  localparam int CV_W  = NUM_PLATS * COLOR_W;

  localparam logic [POS_W-1:0] START_POS  = POS_W'(START_Y);
  localparam logic [POS_W:0]   HIT_EXT    = (POS_W+1)'(HIT_WINDOW);
  localparam logic [POS_W:0]   FLOOR_EXT  = (POS_W+1)'(FLOOR_Y);
  localparam logic [UPC_W-1:0] UPC_RELOAD = UPC_W'(BOUNCE_STEPS - 1);

  function automatic logic [CV_W-1:0] init_colors();
    logic [CV_W-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_PLATS; i++) begin
      v[i*COLOR_W +: COLOR_W] = COLOR_W'(i);
    end
    return v;
  endfunction

  localparam logic [CV_W-1:0] INIT_COLORS = init_colors();

  state_e                 state_q, state_d;
  logic [POS_W-1:0]       ball_q, ball_d, prev_q, prev_d;
  logic [COLOR_W-1:0]     bcolor_q, bcolor_d;
  logic [CV_W-1:0]        pcolors_q, pcolors_d;
  logic [SCORE_W-1:0]     score_q, score_d, high_q, high_d;
  logic                   over_q, over_d, hit_q, hit_d, miss_q, miss_d;
  logic [UPC_W-1:0]       upc_q, upc_d;
  logic [NUM_PLATS-1:0]   keys_q, keys_d, latch_q, latch_d;

  logic [CV_W-1:0]        draw_colors_s;
  logic [IDX_W-1:0]       target_idx_s;
  logic [COLOR_W-1:0]     target_color_s;
  logic [NUM_PLATS-1:0]   press_s;
  logic [IDX_W-1:0]       press_idx_s;
  logic [POS_W-1:0]       plat_sel_s;
  logic                   in_window_s, hit_cond_s, fail_s, loss_s;
  logic [POS_W:0]         fall_pos_s;
  logic [POS_W-1:0]       rise_pos_s;
  logic [SCORE_W-1:0]     score_inc_s, high_max_s;

  color_lfsr_picker #(
    .NUM_PLATS (NUM_PLATS),
    .COLOR_W   (COLOR_W),
    .LFSR_SEED (LFSR_SEED),
    .IDX_W     (IDX_W)
  ) u_picker (
    .clk           (clk),
    .reset         (reset),
    .draw_colors_o (draw_colors_s),
    .target_idx_o  (target_idx_s)
  );

  // Press decode, window test and step arithmetic for the current tick.
  always_comb begin
    target_color_s = draw_colors_s[target_idx_s*COLOR_W +: COLOR_W];
    press_s        = keys_q & ~bus.keys;
    press_idx_s    = '0;
    for (int i = 0; i < NUM_PLATS; i++) begin
      if (latch_q[i]) begin
        press_idx_s = IDX_W'(i);
      end else begin
        press_idx_s = press_idx_s;
      end
    end
    plat_sel_s  = bus.plat_pos[press_idx_s*POS_W +: POS_W];
    in_window_s = ({1'b0, plat_sel_s} >= {1'b0, ball_q}) &&
                  ({1'b0, plat_sel_s} <= ({1'b0, ball_q} + HIT_EXT));
    hit_cond_s  = $onehot(latch_q) && in_window_s &&
                  (bcolor_q == pcolors_q[press_idx_s*COLOR_W +: COLOR_W]);
    fail_s      = (latch_q != '0) && !hit_cond_s;
    fall_pos_s  = {1'b0, ball_q} + {{POS_W{1'b0}}, 1'b1};
    loss_s      = (fall_pos_s >= FLOOR_EXT);
    rise_pos_s  = (ball_q == '0) ? '0 : (ball_q - {{(POS_W-1){1'b0}}, 1'b1});
    score_inc_s = (score_q == 16'hFFFF) ? score_q : (score_q + 16'd1);
    high_max_s  = (score_q > high_q) ? score_q : high_q;
  end

  // Game FSM next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    ball_d    = ball_q;
    prev_d    = prev_q;
    bcolor_d  = bcolor_q;
    pcolors_d = pcolors_q;
    score_d   = score_q;
    high_d    = high_q;
    over_d    = over_q;
    upc_d     = upc_q;
    hit_d     = 1'b0;
    miss_d    = 1'b0;
    keys_d    = bus.keys;
    // A press on the tick cycle itself belongs to the next window.
    latch_d   = bus.tick ? press_s : (latch_q | press_s);

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (bus.start) begin
          state_d   = ST_FALL;
          ball_d    = START_POS;
          prev_d    = START_POS;
          score_d   = '0;
          pcolors_d = draw_colors_s;
          bcolor_d  = target_color_s;
          latch_d   = '0;
          over_d    = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_FALL: begin
        if (bus.tick) begin
          prev_d = ball_q;
          if (loss_s) begin
            ball_d  = fall_pos_s[POS_W-1:0];
            miss_d  = fail_s;
            state_d = ST_OVER;
            over_d  = 1'b1;
            high_d  = high_max_s;
          end else if (hit_cond_s) begin
            ball_d    = rise_pos_s;
            upc_d     = UPC_RELOAD;
            score_d   = score_inc_s;
            pcolors_d = draw_colors_s;
            bcolor_d  = target_color_s;
            hit_d     = 1'b1;
            state_d   = ST_RISE;
          end else begin
            ball_d = fall_pos_s[POS_W-1:0];
            miss_d = fail_s;
            if (fail_s && (MISS_KILLS != 0)) begin
              state_d = ST_OVER;
              over_d  = 1'b1;
              high_d  = high_max_s;
            end else begin
              state_d = ST_FALL;
            end
          end
        end else begin
          state_d = ST_FALL;
        end
      end
      ST_RISE: begin
        if (bus.tick) begin
          prev_d = ball_q;
          ball_d = rise_pos_s;
          if (upc_q == '0) begin
            state_d = ST_FALL;
          end else begin
            upc_d = upc_q - {{(UPC_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = ST_RISE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ball_q    <= START_POS;
      prev_q    <= START_POS;
      bcolor_q  <= INIT_COLORS[COLOR_W-1:0];
      pcolors_q <= INIT_COLORS;
      score_q   <= '0;
      high_q    <= '0;
      over_q    <= 1'b0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
      upc_q     <= '0;
      keys_q    <= '1;
      latch_q   <= '0;
    end else begin
      state_q   <= state_d;
      ball_q    <= ball_d;
      prev_q    <= prev_d;
      bcolor_q  <= bcolor_d;
      pcolors_q <= pcolors_d;
      score_q   <= score_d;
      high_q    <= high_d;
      over_q    <= over_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
      upc_q     <= upc_d;
      keys_q    <= keys_d;
      latch_q   <= latch_d;
    end
  end

  assign bus.ball_pos    = ball_q;
  assign bus.prev_ball   = prev_q;
  assign bus.ball_color  = bcolor_q;
  assign bus.plat_colors = pcolors_q;
  assign bus.score       = score_q;
  assign bus.high_score  = high_q;
  assign bus.gameover    = over_q;
  assign bus.hit         = hit_q;
  assign bus.miss        = miss_q;

endmodule
